// File: rtl/rf_pkg.sv
// Shared widths, typedefs and request payload for the register-file write path.
package rf_pkg;

  localparam int unsigned REG_ADDR_W = 2;
  localparam int unsigned REG_DATA_W = 8;
  localparam int unsigned NUM_REGS   = 4;

  typedef logic [REG_ADDR_W-1:0]        reg_addr_t;
  typedef logic signed [REG_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reserve/clear, WAW stall, RAW hazard, sticky unreserved-write flag.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rsv_valid,
  input  reg_addr_t           rsv_addr,
  input  logic                clr_en,
  input  reg_addr_t           clr_addr,
  input  logic                wr_fire,
  input  reg_addr_t           wr_addr,
  input  reg_addr_t           chk_ra,
  input  reg_addr_t           chk_rb,
  output logic                rsv_ready,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy,
  output logic                err_unrsv
);

  logic                rsv_fire;
  logic [NUM_REGS-1:0] busy_next;

  assign rsv_ready = ~busy[rsv_addr];
  assign rsv_fire  = rsv_valid & rsv_ready;
  assign hazard    = busy[chk_ra] | busy[chk_rb];

  // Reserve is applied after clear so a same-address collision leaves the bit set.
  always_comb begin
    busy_next = busy;
    if (clr_en)   busy_next[clr_addr] = 1'b0;
    if (rsv_fire) busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      err_unrsv <= 1'b0;
    end else begin
      busy <= busy_next;
      if (wr_fire && !busy[wr_addr]) err_unrsv <= 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the register-file write port plus busy scoreboard.
// Optional RF_ARB_ROUND_ROBIN_EN: round-robin on contention; otherwise load unit (req1) always wins.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  reg_addr_t           req0_addr,
  input  reg_data_t           req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  reg_addr_t           req1_addr,
  input  reg_data_t           req1_data,
  output reg_addr_t           rf_wb,
  output reg_data_t           rf_data,
  output logic                rf_we,
  input  logic                rsv_valid,
  input  reg_addr_t           rsv_addr,
  output logic                rsv_ready,
  input  reg_addr_t           chk_ra,
  input  reg_addr_t           chk_rb,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy,
  output logic                err_unrsv
);

  wr_req_t req0, req1, winner;
  logic    contend, pick1, grant1, fire;

  assign req0    = '{valid: req0_valid, addr: req0_addr, data: req0_data};
  assign req1    = '{valid: req1_valid, addr: req1_addr, data: req1_data};
  assign contend = req0.valid & req1.valid;

`ifdef RF_ARB_ROUND_ROBIN_EN
  // Index of the last contended winner; reset to 1 so req0 takes the first contention.
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst)          last_grant <= 1'b1;
    else if (contend) last_grant <= pick1;
  end

  assign pick1 = ~last_grant;
`else
  assign pick1 = 1'b1;
`endif

  assign grant1     = req1.valid & (~req0.valid | pick1);
  assign req1_ready = grant1;
  assign req0_ready = req0.valid & ~grant1;
  assign fire       = req0.valid | req1.valid;
  assign winner     = grant1 ? req1 : req0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_wb   <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= fire;
      if (fire) begin
        rf_wb   <= winner.addr;
        rf_data <= winner.data;
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .clr_en    (rf_we),
    .clr_addr  (rf_wb),
    .wr_fire   (fire),
    .wr_addr   (winner.addr),
    .chk_ra    (chk_ra),
    .chk_rb    (chk_rb),
    .rsv_ready (rsv_ready),
    .hazard    (hazard),
    .busy      (busy),
    .err_unrsv (err_unrsv)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (default or RF_ARB_ROUND_ROBIN_EN build).
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  reg_addr_t req0_addr, req1_addr, rf_wb, rsv_addr, chk_ra, chk_rb;
  reg_data_t req0_data, req1_data, rf_data;
  logic rf_we, rsv_valid, rsv_ready, hazard, err_unrsv;
  logic [NUM_REGS-1:0] busy;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_wb(rf_wb), .rf_data(rf_data), .rf_we(rf_we),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .hazard(hazard), .busy(busy), .err_unrsv(err_unrsv)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
    req0_data = 0; req1_data = 0; rsv_valid = 0; rsv_addr = 0; chk_ra = 1; chk_rb = 1;
    step(); step();
    chk_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_we got %b exp 0", rf_we); else pass_cnt++;
    chk_cnt++; if (rf_wb !== 2'd0) $display("FAIL reset_wb got %0d exp 0", rf_wb); else pass_cnt++;
    chk_cnt++; if (rf_data !== 8'sh00) $display("FAIL reset_data got %h exp 00", rf_data); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL reset_busy got %b exp 0000", busy); else pass_cnt++;
    chk_cnt++; if (err_unrsv !== 1'b0) $display("FAIL reset_err got %b exp 0", err_unrsv); else pass_cnt++;
    chk_cnt++; if (rsv_ready !== 1'b1) $display("FAIL reset_rsv_ready got %b exp 1", rsv_ready); else pass_cnt++;
    chk_cnt++; if (hazard !== 1'b0) $display("FAIL reset_hazard got %b exp 0", hazard); else pass_cnt++;
    req0_valid = 1; #1;
    chk_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL reset_ready got %b exp 10", {req0_ready, req1_ready}); else pass_cnt++;
    req0_valid = 0; step();
    chk_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_hold_we got %b exp 0", rf_we); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    rsv_valid = 1; rsv_addr = 2; step(); rsv_valid = 0;
    chk_cnt++; if (busy !== 4'b0100) $display("FAIL single_rsv_busy got %b exp 0100", busy); else pass_cnt++;
    req0_valid = 1; req0_addr = 2; req0_data = 8'sh5A; #1;
    chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL single_ready got %b exp 1", req0_ready); else pass_cnt++;
    step(); req0_valid = 0;
    chk_cnt++; if (rf_we !== 1'b1) $display("FAIL single_we got %b exp 1", rf_we); else pass_cnt++;
    chk_cnt++; if (rf_wb !== 2'd2) $display("FAIL single_wb got %0d exp 2", rf_wb); else pass_cnt++;
    chk_cnt++; if (rf_data !== 8'sh5A) $display("FAIL single_data got %h exp 5a", rf_data); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0100) $display("FAIL single_busy_hold got %b exp 0100", busy); else pass_cnt++;
    step();
    chk_cnt++; if (rf_we !== 1'b0) $display("FAIL single_we_drop got %b exp 0", rf_we); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL single_busy_clr got %b exp 0000", busy); else pass_cnt++;
    chk_cnt++; if (rf_data !== 8'sh5A) $display("FAIL single_data_hold got %h exp 5a", rf_data); else pass_cnt++;
    chk_cnt++; if (err_unrsv !== 1'b0) $display("FAIL single_err got %b exp 0", err_unrsv); else pass_cnt++;
  endtask

  task automatic test_waw();
    rsv_valid = 1; rsv_addr = 1; step();
    chk_cnt++; if (busy !== 4'b0010) $display("FAIL waw_busy got %b exp 0010", busy); else pass_cnt++;
    chk_cnt++; if (rsv_ready !== 1'b0) $display("FAIL waw_stall0 got %b exp 0", rsv_ready); else pass_cnt++;
    step();
    chk_cnt++; if (rsv_ready !== 1'b0) $display("FAIL waw_stall1 got %b exp 0", rsv_ready); else pass_cnt++;
    req1_valid = 1; req1_addr = 1; req1_data = 8'sh33; step(); req1_valid = 0;
    chk_cnt++; if (rsv_ready !== 1'b0) $display("FAIL waw_stall2 got %b exp 0", rsv_ready); else pass_cnt++;
    step();
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL waw_clr got %b exp 0000", busy); else pass_cnt++;
    chk_cnt++; if (rsv_ready !== 1'b1) $display("FAIL waw_release got %b exp 1", rsv_ready); else pass_cnt++;
    step(); rsv_valid = 0;
    chk_cnt++; if (busy !== 4'b0010) $display("FAIL waw_rsv2 got %b exp 0010", busy); else pass_cnt++;
    req0_valid = 1; req0_addr = 1; req0_data = 8'sh01; step(); req0_valid = 0; step();
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL waw_cleanup got %b exp 0000", busy); else pass_cnt++;
  endtask

  task automatic test_hazard();
    rsv_valid = 1; rsv_addr = 0; step(); rsv_valid = 0;
    chk_ra = 0; chk_rb = 1; #1;
    chk_cnt++; if (hazard !== 1'b1) $display("FAIL hazard_ra got %b exp 1", hazard); else pass_cnt++;
    chk_ra = 1; chk_rb = 1; #1;
    chk_cnt++; if (hazard !== 1'b0) $display("FAIL hazard_none got %b exp 0", hazard); else pass_cnt++;
    chk_rb = 0; #1;
    chk_cnt++; if (hazard !== 1'b1) $display("FAIL hazard_rb got %b exp 1", hazard); else pass_cnt++;
    chk_ra = 0; chk_rb = 1;
    req0_valid = 1; req0_addr = 0; req0_data = -8'sd5; step(); req0_valid = 0;
    chk_cnt++; if (hazard !== 1'b1) $display("FAIL hazard_hold got %b exp 1", hazard); else pass_cnt++;
    step();
    chk_cnt++; if (hazard !== 1'b0) $display("FAIL hazard_clr got %b exp 0", hazard); else pass_cnt++;
    chk_ra = 1;
  endtask

  task automatic test_same_edge();
    req1_valid = 1; req1_addr = 3; req1_data = 8'sh77; step(); req1_valid = 0;
    chk_cnt++; if (err_unrsv !== 1'b1) $display("FAIL same_err got %b exp 1", err_unrsv); else pass_cnt++;
    rsv_valid = 1; rsv_addr = 3; #1;
    chk_cnt++; if (rsv_ready !== 1'b1) $display("FAIL same_rsv_ready got %b exp 1", rsv_ready); else pass_cnt++;
    step(); rsv_valid = 0;
    chk_cnt++; if (busy !== 4'b1000) $display("FAIL same_busy got %b exp 1000", busy); else pass_cnt++;
    req0_valid = 1; req0_addr = 3; req0_data = 8'sh00; step(); req0_valid = 0; step();
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL same_cleanup got %b exp 0000", busy); else pass_cnt++;
  endtask

  task automatic test_contention();
    logic exp1;
    req0_valid = 1; req0_addr = 0; req0_data = 8'sh10;
    req1_valid = 1; req1_addr = 1; req1_data = 8'sh21;
    for (int i = 0; i < 4; i++) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
      exp1 = (i % 2) == 1;
`else
      exp1 = 1'b1;
`endif
      #1;
      chk_cnt++; if ({req0_ready, req1_ready} !== {~exp1, exp1}) $display("FAIL contend_grant%0d got %b exp %b", i, {req0_ready, req1_ready}, {~exp1, exp1}); else pass_cnt++;
      step();
      chk_cnt++; if (rf_data !== (exp1 ? 8'sh21 : 8'sh10)) $display("FAIL contend_data%0d got %h exp %h", i, rf_data, exp1 ? 8'sh21 : 8'sh10); else pass_cnt++;
    end
    req0_valid = 0; req1_valid = 0; step(); step();
  endtask

  task automatic test_unrsv_reset();
    rst = 1; step(); rst = 0;
    chk_cnt++; if (err_unrsv !== 1'b0) $display("FAIL unrsv_pre got %b exp 0", err_unrsv); else pass_cnt++;
    req1_valid = 1; req1_addr = 3; req1_data = 8'sh3C; rsv_valid = 1; rsv_addr = 0;
    step(); req1_valid = 0; rsv_valid = 0;
    chk_cnt++; if (err_unrsv !== 1'b1) $display("FAIL unrsv_err got %b exp 1", err_unrsv); else pass_cnt++;
    chk_cnt++; if ({rf_we, rf_wb, busy} !== {1'b1, 2'd3, 4'b0001}) $display("FAIL unrsv_commit got %b exp 1110001", {rf_we, rf_wb, busy}); else pass_cnt++;
    rst = 1; step(); rst = 0;
    chk_cnt++; if (rf_we !== 1'b0) $display("FAIL rst_mid_we got %b exp 0", rf_we); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL rst_mid_busy got %b exp 0000", busy); else pass_cnt++;
    chk_cnt++; if (err_unrsv !== 1'b0) $display("FAIL rst_mid_err got %b exp 0", err_unrsv); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_waw();
    test_hazard();
    test_same_edge();
    test_contention();
    test_unrsv_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
